regfile_wb_scheduler: RTL and testbench

Sequences all writes into the 64-bit register file and tracks pending destinations so that issue stalls on hazards. It arbitrates two writeback requesters, ALU (req0) and memory load (req1), onto the single register-file write port using round-robin. It also keeps a per-register pending scoreboard that stalls instruction issue on RAW and WAW hazards. The block sits between the issue/execute stages and the register file's write_enable/dest_addr/write_data inputs.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/regfile_wb_scheduler.sv | 119 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register-file writeback scheduler.
package regfile_pkg;

    localparam int DEFAULT_BIT_NUMBER      = 64;
    localparam int DEFAULT_ADDR_NUMBER     = 5;
    localparam int DEFAULT_REGISTER_NUMBER = 16;

    // One writeback request as seen by the write port.
    typedef struct packed {
        logic                           valid;
        logic [DEFAULT_ADDR_NUMBER-1:0] addr;
        logic [DEFAULT_BIT_NUMBER-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with one-hot grants.
// The pointer names the preferred requester and only moves on contention.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // 0 prefers req[0], 1 prefers req[1]
    logic ptr;

    // Grant the sole requester, or the preferred one when both request.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // Hand preference to the loser after a contended grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (req == 2'b11) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: arbitrates ALU and load writebacks onto the single
// register-file write port and keeps a pending scoreboard for issue hazards.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int BIT_NUMBER      = DEFAULT_BIT_NUMBER,
    parameter int ADDR_NUMBER     = DEFAULT_ADDR_NUMBER,
    parameter int REGISTER_NUMBER = DEFAULT_REGISTER_NUMBER
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req0_valid,
    input  logic [ADDR_NUMBER-1:0]     req0_addr,
    input  logic [BIT_NUMBER-1:0]      req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [ADDR_NUMBER-1:0]     req1_addr,
    input  logic [BIT_NUMBER-1:0]      req1_data,
    output logic                       req1_ready,
    input  logic                       issue_valid,
    input  logic [ADDR_NUMBER-1:0]     issue_src1,
    input  logic [ADDR_NUMBER-1:0]     issue_src2,
    input  logic [ADDR_NUMBER-1:0]     issue_dest,
    input  logic                       issue_has_dest,
    output logic                       issue_stall,
    output logic                       wr_en,
    output logic [ADDR_NUMBER-1:0]     wr_addr,
    output logic [BIT_NUMBER-1:0]      wr_data,
    output logic [REGISTER_NUMBER-1:0] pending
);

    logic [1:0]                 grant;
    wb_req_t                    sel;
    logic                       write_fire;
    logic                       src1_pend;
    logic                       src2_pend;
    logic                       dest_pend;
    logic                       issue_accept;
    logic [REGISTER_NUMBER-1:0] pending_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Mux the granted request onto the write path.
    always_comb begin
        sel = '0;
        if (grant[0]) begin
            sel.valid = 1'b1;
            sel.addr  = req0_addr;
            sel.data  = req0_data;
        end else if (grant[1]) begin
            sel.valid = 1'b1;
            sel.addr  = req1_addr;
            sel.data  = req1_data;
        end
    end

    // Out-of-range destinations are consumed but never reach the register file.
    assign write_fire = sel.valid && (sel.addr < ADDR_NUMBER'(REGISTER_NUMBER));

    // Scoreboard lookups; addresses beyond the implemented range read as clear.
    always_comb begin
        src1_pend = 1'b0;
        src2_pend = 1'b0;
        dest_pend = 1'b0;
        for (int i = 0; i < REGISTER_NUMBER; i++) begin
            if (issue_src1 == ADDR_NUMBER'(i)) src1_pend = pending[i];
            if (issue_src2 == ADDR_NUMBER'(i)) src2_pend = pending[i];
            if (issue_dest == ADDR_NUMBER'(i)) dest_pend = pending[i];
        end
    end

    assign issue_stall  = issue_valid & (src1_pend | src2_pend | (issue_has_dest & dest_pend));
    assign issue_accept = issue_valid & ~issue_stall;

    // Next scoreboard: clear on the write that wr_en is about to show, then
    // apply the issue set so a same-cycle set overrides the clear.
    always_comb begin
        pending_d = pending;
        for (int i = 0; i < REGISTER_NUMBER; i++) begin
            if (write_fire && sel.addr == ADDR_NUMBER'(i)) pending_d[i] = 1'b0;
            if (issue_accept && issue_has_dest && issue_dest == ADDR_NUMBER'(i)) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

    // Registered write port; address/data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= write_fire;
            if (write_fire) begin
                wr_addr <= sel.addr[ADDR_NUMBER-1:0];
                wr_data <= sel.data[BIT_NUMBER-1:0];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [63:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [63:0] req1_data;
    logic        req1_ready;
    logic        issue_valid;
    logic [4:0]  issue_src1;
    logic [4:0]  issue_src2;
    logic [4:0]  issue_dest;
    logic        issue_has_dest;
    logic        issue_stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [15:0] pending;

    int checks = 0;
    int failures = 0;

    logic [63:0] rf [16];

    regfile_wb_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .issue_valid    (issue_valid),
        .issue_src1     (issue_src1),
        .issue_src2     (issue_src2),
        .issue_dest     (issue_dest),
        .issue_has_dest (issue_has_dest),
        .issue_stall    (issue_stall),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    // Register file model: writes on negedge from the registered port.
    always @(negedge clk) begin
        if (wr_en && wr_addr < 5'd16) rf[wr_addr[3:0]] <= wr_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 64'd0;
        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 64'd0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 64'd0;
        issue_valid = 1'b0; issue_src1 = 5'd0; issue_src2 = 5'd0;
        issue_dest = 5'd0; issue_has_dest = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_wr_en", 64'(wr_en), 64'd0);
            check("idle_pending", 64'(pending), 64'd0);
            check("idle_rdy0", 64'(req0_ready), 64'd0);
            check("idle_rdy1", 64'(req1_ready), 64'd0);
            check("idle_stall", 64'(issue_stall), 64'd0);
        end

        // Single ALU request, 1-cycle latency
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'hAA;
        #1;
        check("single_rdy0", 64'(req0_ready), 64'd1);
        check("single_rdy1", 64'(req1_ready), 64'd0);
        step();
        req0_valid = 1'b0;
        check("single_wr_en", 64'(wr_en), 64'd1);
        check("single_wr_addr", 64'(wr_addr), 64'd3);
        check("single_wr_data", wr_data, 64'hAA);
        step();
        check("single_wr_en_off", 64'(wr_en), 64'd0);
        check("single_addr_hold", 64'(wr_addr), 64'd3);
        check("single_data_hold", wr_data, 64'hAA);

        // Contention: grants alternate starting with req0
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_rdy0", 64'(req0_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_rdy1", 64'(req1_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
            step();
            check("rr_wr_en", 64'(wr_en), 64'd1);
            check("rr_wr_addr", 64'(wr_addr), (k % 2 == 0) ? 64'd1 : 64'd2);
            check("rr_wr_data", wr_data, (k % 2 == 0) ? 64'h11 : 64'h22);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // RAW hazard on r5
        issue_valid = 1'b1; issue_dest = 5'd5; issue_has_dest = 1'b1;
        issue_src1 = 5'd0; issue_src2 = 5'd0;
        #1;
        check("raw_issue_nostall", 64'(issue_stall), 64'd0);
        step();
        check("raw_pending_set", 64'(pending), 64'h0020);
        issue_src1 = 5'd5; issue_has_dest = 1'b0; issue_dest = 5'd0;
        #1;
        check("raw_stall", 64'(issue_stall), 64'd1);
        step();
        check("raw_stall_hold", 64'(issue_stall), 64'd1);
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 64'h55;
        #1;
        check("raw_rdy1", 64'(req1_ready), 64'd1);
        check("raw_stall_before_wb", 64'(issue_stall), 64'd1);
        step();
        req1_valid = 1'b0;
        check("raw_wr_en", 64'(wr_en), 64'd1);
        check("raw_wr_addr", 64'(wr_addr), 64'd5);
        check("raw_pending_clr", 64'(pending), 64'd0);
        check("raw_stall_drop", 64'(issue_stall), 64'd0);
        @(negedge clk);
        #1;
        check("raw_rf_read", rf[5], 64'h55);
        issue_valid = 1'b0; issue_src1 = 5'd0;
        step();

        // Same-cycle set and clear of r7: set wins
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'h77;
        issue_valid = 1'b1; issue_dest = 5'd7; issue_has_dest = 1'b1;
        #1;
        check("setwin_nostall", 64'(issue_stall), 64'd0);
        step();
        req0_valid = 1'b0; issue_valid = 1'b0;
        check("setwin_wr_en", 64'(wr_en), 64'd1);
        check("setwin_wr_addr", 64'(wr_addr), 64'd7);
        check("setwin_pending", 64'(pending), 64'h0080);

        // WAW stall on pending r7, out-of-range dest ignored
        issue_valid = 1'b1; issue_dest = 5'd7; issue_has_dest = 1'b1;
        #1;
        check("waw_stall", 64'(issue_stall), 64'd1);
        issue_dest = 5'd20;
        #1;
        check("oor_dest_nostall", 64'(issue_stall), 64'd0);
        step();
        issue_valid = 1'b0;
        check("oor_dest_pending", 64'(pending), 64'h0080);

        // Out-of-range writeback accepted without a write
        req0_valid = 1'b1; req0_addr = 5'd20; req0_data = 64'hDEAD;
        #1;
        check("oor_wb_rdy0", 64'(req0_ready), 64'd1);
        step();
        req0_valid = 1'b0;
        check("oor_wb_wr_en", 64'(wr_en), 64'd0);
        check("oor_wb_pending", 64'(pending), 64'h0080);

        // Set r4 pending, move pointer to req1, then reset with req1 accepted
        issue_valid = 1'b1; issue_dest = 5'd4; issue_has_dest = 1'b1;
        step();
        issue_valid = 1'b0;
        check("rst_pre_pending", 64'(pending), 64'h0090);
        req0_valid = 1'b1; req0_addr = 5'd21;
        req1_valid = 1'b1; req1_addr = 5'd22;
        #1;
        check("rst_pre_rdy0", 64'(req0_ready), 64'd1);
        step();
        check("rst_ptr_moved", 64'(req1_ready), 64'd1);
        req0_valid = 1'b0;
        req1_addr = 5'd4; req1_data = 64'h44;
        reset = 1'b1;
        #1;
        check("rst_req1_rdy", 64'(req1_ready), 64'd1);
        step();
        reset = 1'b0; req1_valid = 1'b0;
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        step();
        check("rst_after_wr_en", 64'(wr_en), 64'd0);
        req0_valid = 1'b1; req0_addr = 5'd1;
        req1_valid = 1'b1; req1_addr = 5'd2;
        #1;
        check("rst_ptr_rdy0", 64'(req0_ready), 64'd1);
        check("rst_ptr_rdy1", 64'(req1_ready), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
